fill_readout_sequencer: RTL and testbench

//  Sequences readout of one fill after the trigger manager logs its 24-bit trigger number in the fill-number FIFO.

---
 rtl/fill_readout_sequencer_pkg.sv | 23 ++
 rtl/fill_readout_sequencer_lowest_bit_select.sv | 28 ++
 rtl/fill_readout_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fill_readout_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_readout_sequencer_pkg.sv
// Shared constants for the fill readout sequencer: one-hot state layout, frame tags, word-count width.
package fill_readout_sequencer_pkg;

  localparam int S_IDLE     = 0;
  localparam int S_HEADER   = 1;
  localparam int S_SELECT   = 2;
  localparam int S_STREAM   = 3;
  localparam int S_TRAILER  = 4;
  localparam int NUM_STATES = 5;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE    = NUM_STATES'(1 << S_IDLE),
    ST_HEADER  = NUM_STATES'(1 << S_HEADER),
    ST_SELECT  = NUM_STATES'(1 << S_SELECT),
    ST_STREAM  = NUM_STATES'(1 << S_STREAM),
    ST_TRAILER = NUM_STATES'(1 << S_TRAILER)
  } state_e;

  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;
  localparam int         CNT_W   = 16;

endpackage

// File: rtl/fill_readout_sequencer_lowest_bit_select.sv
// Picks the lowest set bit of a mask: one-hot grant, its index, and a flag when the mask is empty.
// Purely combinational, no latency, no backpressure.
module fill_readout_sequencer_lowest_bit_select #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             none
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    grant = '0;
    index = '0;
    none  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fill_readout_sequencer.sv
// Per fill-number entry: header, each enabled channel's stream in ascending order, then trailer.
// Channel words pass through with zero latency; every output beat, including header/trailer, waits on out_ready.
module fill_readout_sequencer
  import fill_readout_sequencer_pkg::*;
#(
  parameter int NUM_CHAN       = 5,
  parameter int TRIG_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fn_valid,
  input  logic [TRIG_W-1:0]          fn_data,
  output logic                       fn_rd,
  input  logic [NUM_CHAN-1:0]        chan_en,
  output logic [NUM_CHAN-1:0]        chan_req,
  input  logic [NUM_CHAN-1:0]        chan_valid,
  input  logic [NUM_CHAN-1:0]        chan_last,
  input  logic [NUM_CHAN*DATA_W-1:0] chan_data,
  output logic [NUM_CHAN-1:0]        chan_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [NUM_CHAN-1:0]        err_chan
);

  localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [TRIG_W-1:0]    trig_q;
  logic [NUM_CHAN-1:0]  mask_q;
  logic [NUM_CHAN-1:0]  grant_q;
  logic [IDX_W-1:0]     sel_q;
  logic [NUM_CHAN-1:0]  err_q;
  logic [CNT_W-1:0]     word_cnt_q;
  logic [TMR_W-1:0]     timer_q;

  logic [NUM_CHAN-1:0]  sel_grant;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_none;
  logic                 cur_vld;
  logic                 cur_last;
  logic                 beat;
  logic                 tmo_hit;

  fill_readout_sequencer_lowest_bit_select #(
    .N     (NUM_CHAN),
    .IDX_W (IDX_W)
  ) u_sel (
    .mask  (mask_q),
    .grant (sel_grant),
    .index (sel_idx),
    .none  (sel_none)
  );

  assign cur_vld  = |(chan_valid & grant_q);
  assign cur_last = |(chan_last & grant_q);
  assign beat     = (state_q == ST_STREAM) && cur_vld && out_ready;
  // A beat in the final timer cycle takes priority over abandoning the channel.
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (state_q == ST_STREAM) && !beat && (timer_q == TMR_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fn_rd      = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    chan_req   = '0;
    chan_ready = '0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        // Gated with reset so fn_rd is also held low while reset is asserted.
        if (fn_valid && reset) begin
          fn_rd   = 1'b1;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        out_valid                = 1'b1;
        out_data[DATA_W-1 -: 8]  = HDR_TAG;
        out_data[TRIG_W-1:0]     = trig_q;
        if (out_ready) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        state_d = sel_none ? ST_TRAILER : ST_STREAM;
      end
      ST_STREAM: begin
        chan_req   = grant_q;
        chan_ready = grant_q & {NUM_CHAN{out_ready}};
        out_valid  = cur_vld;
        out_data   = chan_data[int'(sel_q) * DATA_W +: DATA_W];
        if ((beat && cur_last) || tmo_hit) state_d = ST_SELECT;
      end
      ST_TRAILER: begin
        out_valid                    = 1'b1;
        out_last                     = 1'b1;
        out_data[DATA_W-1 -: 8]      = TRL_TAG;
        out_data[CNT_W +: NUM_CHAN]  = err_q;
        out_data[CNT_W-1:0]          = word_cnt_q;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_q      <= '0;
      mask_q      <= '0;
      grant_q     <= '0;
      sel_q       <= '0;
      err_q       <= '0;
      word_cnt_q  <= '0;
      timer_q     <= '0;
      timeout_err <= 1'b0;
      err_chan    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fn_valid) begin
            trig_q     <= fn_data;
            mask_q     <= chan_en;
            word_cnt_q <= '0;
            err_q      <= '0;
          end
        end
        ST_SELECT: begin
          sel_q   <= sel_idx;
          grant_q <= sel_grant;
          mask_q  <= mask_q & ~sel_grant;
          timer_q <= '0;
        end
        ST_STREAM: begin
          if (beat) begin
            if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + 1'b1;
            timer_q <= '0;
          end else if (tmo_hit) begin
            err_q       <= err_q | grant_q;
            timeout_err <= 1'b1;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_TRAILER: begin
          if (out_ready) err_chan <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_readout_sequencer.sv
// Bench for fill_readout_sequencer with a 16-cycle channel timeout.
module tb_fill_readout_sequencer;

  localparam int NCH = 5;
  localparam int TW  = 24;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              fn_valid = 1'b0;
  logic [TW-1:0]     fn_data = '0;
  logic              fn_rd;
  logic [NCH-1:0]    chan_en = '0;
  logic [NCH-1:0]    chan_req;
  logic [NCH-1:0]    chan_valid = '0;
  logic [NCH-1:0]    chan_last = '0;
  logic [NCH*DW-1:0] chan_data = '0;
  logic [NCH-1:0]    chan_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              timeout_err;
  logic [NCH-1:0]    err_chan;

  always #5 clk = ~clk;

  fill_readout_sequencer #(
    .NUM_CHAN       (NCH),
    .TRIG_W         (TW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fn_valid    (fn_valid),
    .fn_data     (fn_data),
    .fn_rd       (fn_rd),
    .chan_en     (chan_en),
    .chan_req    (chan_req),
    .chan_valid  (chan_valid),
    .chan_last   (chan_last),
    .chan_data   (chan_data),
    .chan_ready  (chan_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_chan    (err_chan)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0]    exp_q[$];
  logic [9:0]     fill_q[$];
  logic [28:0]    fn_q[$];
  logic [32:0]    chq[NCH][$];
  int             gap[NCH];
  int             run[NCH];
  logic [NCH-1:0] dead_mask = '0;
  logic           pop_fn = 1'b0;
  logic [NCH-1:0] acc = '0;
  int             lowrun = 0;
  int             fn_rd_cnt = 0;
  logic           held_vld = 1'b0;
  logic [32:0]    held_word = '0;
  logic           exp_fn_rd = 1'b0;
  logic           pend_err = 1'b0;
  logic [NCH-1:0] pend_err_val = '0;
  logic [NCH-1:0] req_acc = '0;
  logic [9:0]     f_ent;
  logic [32:0]    w_ent;
  logic [32:0]    drv_h;

  logic [51:0] all_outs;
  assign all_outs = {fn_rd, chan_req, chan_ready, out_valid, out_data, out_last, busy, timeout_err, err_chan};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: header, enabled live channels' words in index order, trailer with err mask and count.
  task automatic issue_fill(input logic [TW-1:0] trig, input logic [NCH-1:0] en, input logic [NCH-1:0] dead,
                            input int nmin, input int nmax, input bit push_fn);
    logic [15:0]    cnt;
    logic [NCH-1:0] err;
    int             n;
    logic [31:0]    w;
    cnt = '0;
    err = '0;
    exp_q.push_back({1'b0, 8'hA5, trig});
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        if (dead[i]) begin
          err[i] = 1'b1;
        end else begin
          n = int'($urandom_range(nmax, nmin));
          for (int k = 0; k < n; k++) begin
            w = $urandom;
            chq[i].push_back({k == n - 1, w});
            exp_q.push_back({1'b0, w});
            if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
          end
        end
      end
    end
    exp_q.push_back({1'b1, 8'h5A, 3'b000, err, cnt});
    fill_q.push_back({en, err});
    if (push_fn) fn_q.push_back({en, trig});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fn_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // Stimulus driver: fill-number FIFO, channel sources with random gaps, random out_ready.
  always @(posedge clk) begin
    #1;
    if (pop_fn && fn_q.size() > 0) fn_q.delete(0);
    for (int i = 0; i < NCH; i++) begin
      if (acc[i] && chq[i].size() > 0) begin
        chq[i].delete(0);
        gap[i] = int'($urandom_range(3, 0));
      end else if (gap[i] > 0) begin
        gap[i] = gap[i] - 1;
      end
    end
    if (fn_q.size() > 0) begin
      fn_valid = 1'b1;
      {chan_en, fn_data} = fn_q[0];
    end else begin
      fn_valid = 1'b0;
      fn_data  = TW'($urandom);
      chan_en  = NCH'($urandom);
    end
    for (int i = 0; i < NCH; i++) begin
      if (chq[i].size() > 0 && gap[i] == 0) begin
        drv_h = chq[i][0];
        chan_valid[i]        = 1'b1;
        chan_last[i]         = drv_h[32];
        chan_data[i*DW +: DW] = drv_h[31:0];
      end else begin
        chan_valid[i]        = 1'b0;
        chan_last[i]         = 1'($urandom);
        chan_data[i*DW +: DW] = $urandom;
      end
    end
    if (lowrun >= 2) out_ready = 1'b1;
    else out_ready = ($urandom_range(2, 0) != 0);
    lowrun = out_ready ? 0 : lowrun + 1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    pop_fn = fn_rd;
    acc    = chan_valid & chan_ready;
    if (!reset) begin
      held_vld  = 1'b0;
      exp_fn_rd = 1'b0;
      pend_err  = 1'b0;
      req_acc   = '0;
      for (int i = 0; i < NCH; i++) run[i] = 0;
    end else begin
      if (fn_rd) fn_rd_cnt++;
      if (pend_err) begin
        chk("err_chan", 64'(err_chan), 64'(pend_err_val));
        pend_err = 1'b0;
      end
      if (exp_fn_rd) begin
        chk("back_to_back_fn_rd", 64'(fn_rd), 64'd1);
        exp_fn_rd = 1'b0;
      end
      if (fn_rd) req_acc = '0;
      req_acc = req_acc | chan_req;
      chk("grant_onehot_ready", 64'({$countones(chan_req) <= 1, chan_ready & ~chan_req}), 64'({1'b1, 5'b00000}));
      if (held_vld) chk("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, held_word}));
      for (int i = 0; i < NCH; i++) begin
        if (chan_req[i]) begin
          run[i] = run[i] + 1;
        end else begin
          if (run[i] != 0 && dead_mask[i]) chk("timeout_grant_cycles", 64'(run[i]), 64'(TMO));
          run[i] = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", {out_last, out_data});
        end else begin
          w_ent = exp_q.pop_front();
          chk("out_word", 64'({out_last, out_data}), 64'(w_ent));
        end
        if (out_last) begin
          if (fill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_trailer: got 0x%0h, expected no trailer", out_data);
          end else begin
            f_ent = fill_q.pop_front();
            chk("granted_channels", 64'(req_acc), 64'(f_ent[9:5]));
            pend_err     = 1'b1;
            pend_err_val = f_ent[4:0];
          end
          if (fn_valid) exp_fn_rd = 1'b1;
        end
      end
      held_vld  = out_valid && !out_ready;
      held_word = {out_last, out_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int fn_before;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(all_outs), 64'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, out_valid, fn_rd}), 64'd0);

    issue_fill(24'h000123, 5'b11111, 5'b00000, 3, 3, 1'b1);
    wait_idle(2000);

    issue_fill(TW'($urandom), 5'b10100, 5'b00000, 2, 5, 1'b1);
    wait_idle(2000);

    fn_before = fn_rd_cnt;
    issue_fill(24'h00BEEF, 5'b00000, 5'b00000, 1, 1, 1'b1);
    wait_idle(2000);
    chk("single_fn_rd", 64'(fn_rd_cnt - fn_before), 64'd1);
    chk("no_timeout_yet", 64'(timeout_err), 64'd0);

    dead_mask = 5'b00010;
    issue_fill(24'h00D00D, 5'b11111, 5'b00010, 2, 2, 1'b1);
    wait_idle(2000);
    dead_mask = 5'b00000;
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    issue_fill(24'h00C1EA, 5'b11111, 5'b00000, 1, 3, 1'b1);
    wait_idle(2000);
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    for (int f = 0; f < 25; f++) issue_fill(TW'($urandom), NCH'($urandom), 5'b00000, 1, 6, 1'b1);
    wait_idle(20000);

    issue_fill(24'hABCDEF, 5'b11111, 5'b00000, 8, 8, 1'b1);
    fn_q.push_back({5'b01011, 24'h0000B0});
    n = 0;
    while (chan_req == '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("stream_reached", 64'(n < 500), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs", 64'(all_outs), 64'd0);
    exp_q.delete();
    fill_q.delete();
    for (int i = 0; i < NCH; i++) chq[i].delete();
    repeat (2) @(negedge clk);
    issue_fill(24'h0000B0, 5'b01011, 5'b00000, 2, 4, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    wait_idle(3000);
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
